// File: rtl/dpram_cfg.sv
// rtl/dpram_cfg.sv - true dual-port RAM with byte lanes, read-during-write modes, optional output register and clear sweep
module dpram_cfg #(
  parameter int ADRW       = 8,
  parameter int DATW       = 32,
  parameter int BYTW       = 8,
  parameter int RDW_NEW    = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 en_a,
  input  logic                 en_b,
  input  logic                 wren_a,
  input  logic                 wren_b,
  input  logic [DATW/BYTW-1:0] be_a,
  input  logic [DATW/BYTW-1:0] be_b,
  input  logic [ADRW-1:0]      address_a,
  input  logic [ADRW-1:0]      address_b,
  input  logic [DATW-1:0]      data_a,
  input  logic [DATW-1:0]      data_b,
  output logic [DATW-1:0]      q_a,
  output logic [DATW-1:0]      q_b,
  output logic                 coll
);
  localparam int NB    = DATW / BYTW;
  localparam int DEPTH = 1 << ADRW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [ADRW-1:0] clr_cnt;
  logic [DATW-1:0] mem [DEPTH];
  logic            run, clearing;
  logic            wr_a, wr_b;
  logic [DATW-1:0] rd_a, rd_b, nw_a, nw_b;
  logic [DATW-1:0] s1_a, s1_b, s2_a, s2_b;

  function automatic logic [DATW-1:0] merge(input logic [DATW-1:0] old,
                                            input logic [DATW-1:0] wd,
                                            input logic [NB-1:0]   be);
    logic [DATW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*BYTW +: BYTW] = wd[i*BYTW +: BYTW];
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (CLR_ON_RST != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
      ready <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == {ADRW{1'b1}}) state_nxt = RUN;
  end

  always_comb begin
    run      = 1'b0;
    clearing = 1'b0;
    case (state)
      CLEAR:   clearing = 1'b1;
      default: run      = 1'b1;
    endcase
  end

  // Post-write word at each port's address; B applied first so A wins overlapping lanes.
  always_comb begin
    wr_a = run & en_a & wren_a;
    wr_b = run & en_b & wren_b;
    rd_a = mem[address_a];
    rd_b = mem[address_b];
    nw_a = rd_a;
    if (wr_b && address_b == address_a) nw_a = merge(nw_a, data_b, be_b);
    if (wr_a) nw_a = merge(nw_a, data_a, be_a);
    nw_b = rd_b;
    if (wr_b) nw_b = merge(nw_b, data_b, be_b);
    if (wr_a && address_a == address_b) nw_b = merge(nw_b, data_a, be_a);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clearing) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr_a) mem[address_a] <= nw_a;
        if (wr_b) mem[address_b] <= nw_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_a <= '0;
      s1_b <= '0;
      s2_a <= '0;
      s2_b <= '0;
      coll <= 1'b0;
    end else begin
      coll <= wr_a & wr_b & (address_a == address_b) & (|(be_a & be_b));
      if (run && en_a && (!wren_a || RDW_NEW != 0)) s1_a <= (RDW_NEW != 0) ? nw_a : rd_a;
      if (run && en_b && (!wren_b || RDW_NEW != 0)) s1_b <= (RDW_NEW != 0) ? nw_b : rd_b;
      if (run) begin
        s2_a <= s1_a;
        s2_b <= s1_b;
      end
    end
  end

  assign q_a = (OUT_REG != 0) ? s2_a : s1_a;
  assign q_b = (OUT_REG != 0) ? s2_b : s1_b;

endmodule

// File: tb/tb_dpram_cfg.sv
// tb/tb_dpram_cfg.sv - scoreboard bench for dpram_cfg, old-data/1-cycle and new-data/2-cycle variants side by side
module tb_dpram_cfg;
  localparam int ADRW = 4;
  localparam int DATW = 32;
  localparam int NB   = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset = 1'b1;
  logic            en_a = 1'b0, en_b = 1'b0, wren_a = 1'b0, wren_b = 1'b0;
  logic [NB-1:0]   be_a = '0, be_b = '0;
  logic [ADRW-1:0] address_a = '0, address_b = '0;
  logic [DATW-1:0] data_a = '0, data_b = '0;
  logic            ready0, ready1, coll0, coll1;
  logic [DATW-1:0] q_a0, q_b0, q_a1, q_b1;

  dpram_cfg #(.ADRW(ADRW), .DATW(DATW), .BYTW(8), .RDW_NEW(0), .OUT_REG(0), .CLR_ON_RST(1)) dut0 (
    .clock(clock), .reset(reset), .ready(ready0),
    .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
    .be_a(be_a), .be_b(be_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a0), .q_b(q_b0), .coll(coll0));

  dpram_cfg #(.ADRW(ADRW), .DATW(DATW), .BYTW(8), .RDW_NEW(1), .OUT_REG(1), .CLR_ON_RST(1)) dut1 (
    .clock(clock), .reset(reset), .ready(ready1),
    .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
    .be_a(be_a), .be_b(be_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a1), .q_b(q_b1), .coll(coll1));

  typedef struct {
    logic [DATW-1:0] qa0, qb0, qa1, qb1;
    logic            coll, ready;
  } exp_t;

  exp_t            sb[$];
  logic [DATW-1:0] mm [16];
  bit              m_clear;
  int              m_cnt;
  logic            m_ready, m_coll;
  logic [DATW-1:0] s1a [2], s1b [2], s2a [2], s2b [2];
  int              errors = 0;
  int              checks = 0;

  task automatic check_eq(input string tag, input logic [DATW-1:0] got, input logic [DATW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane-by-lane result at adr after this cycle's writes; A has priority.
  function automatic logic [DATW-1:0] after_write(input logic [ADRW-1:0] adr);
    logic [DATW-1:0] w;
    w = mm[adr];
    for (int i = 0; i < NB; i++) begin
      if (en_a && wren_a && be_a[i] && address_a == adr)
        w[i*8 +: 8] = data_a[i*8 +: 8];
      else if (en_b && wren_b && be_b[i] && address_b == adr)
        w[i*8 +: 8] = data_b[i*8 +: 8];
    end
    return w;
  endfunction

  task automatic model_step();
    exp_t            e;
    logic [DATW-1:0] nwa, nwb, oa, ob;
    if (reset) begin
      m_clear = 1'b1; m_cnt = 0; m_ready = 1'b0; m_coll = 1'b0;
      for (int d = 0; d < 2; d++) begin
        s1a[d] = '0; s1b[d] = '0; s2a[d] = '0; s2b[d] = '0;
      end
    end else if (m_clear) begin
      mm[m_cnt] = '0;
      if (m_cnt == 15) begin
        m_clear = 1'b0;
        m_ready = 1'b1;
      end
      m_cnt++;
      m_coll = 1'b0;
    end else begin
      nwa = after_write(address_a);
      nwb = after_write(address_b);
      oa  = mm[address_a];
      ob  = mm[address_b];
      for (int d = 0; d < 2; d++) begin
        s2a[d] = s1a[d];
        s2b[d] = s1b[d];
        if (en_a && (!wren_a || d == 1)) s1a[d] = (d == 1) ? nwa : oa;
        if (en_b && (!wren_b || d == 1)) s1b[d] = (d == 1) ? nwb : ob;
      end
      m_coll = en_a && wren_a && en_b && wren_b && address_a == address_b && ((be_a & be_b) != 0);
      if (en_a && wren_a) mm[address_a] = nwa;
      if (en_b && wren_b) mm[address_b] = nwb;
      m_ready = 1'b1;
    end
    e.qa0 = s1a[0]; e.qb0 = s1b[0]; e.qa1 = s2a[1]; e.qb1 = s2b[1];
    e.coll = m_coll; e.ready = m_ready;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_eq("q_a0", q_a0, e.qa0);
    check_eq("q_b0", q_b0, e.qb0);
    check_eq("q_a1", q_a1, e.qa1);
    check_eq("q_b1", q_b1, e.qb1);
    check_eq("coll0", {31'b0, coll0}, {31'b0, e.coll});
    check_eq("coll1", {31'b0, coll1}, {31'b0, e.coll});
    check_eq("ready0", {31'b0, ready0}, {31'b0, e.ready});
    check_eq("ready1", {31'b0, ready1}, {31'b0, e.ready});
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
    be_a = '0; be_b = '0;
  endtask

  task automatic set_a(input logic wr, input logic [ADRW-1:0] adr, input logic [DATW-1:0] d, input logic [NB-1:0] be);
    en_a = 1'b1; wren_a = wr; address_a = adr; data_a = d; be_a = be;
  endtask

  task automatic set_b(input logic wr, input logic [ADRW-1:0] adr, input logic [DATW-1:0] d, input logic [NB-1:0] be);
    en_b = 1'b1; wren_b = wr; address_b = adr; data_b = d; be_b = be;
  endtask

  task automatic prefill_ff();
    for (int i = 0; i < 16; i++) begin
      idle(); set_a(1'b1, ADRW'(i), 32'hFFFF_FFFF, 4'hF); step();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = 'x;
    step(); step();
    check_eq("rst_ready", {31'b0, ready0}, 32'd0);
    check_eq("rst_q", q_a0, 32'd0);

    // Sweep with port traffic: writes dropped, reads give 0.
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, ADRW'(i), 32'hDEAD_0000 + i, 4'hF);
      set_b(1'b0, ADRW'(15 - i), '0, '0);
      step();
      if (i == 7) check_eq("clr_qb", q_b0, 32'd0);
      if (i == 14) check_eq("rdy_lo15", {31'b0, ready0}, 32'd0);
    end
    check_eq("rdy_hi16", {31'b0, ready0}, 32'd1);
    idle();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b0, ADRW'(i), '0, '0); step();
      check_eq("clr_drop", q_a0, 32'd0);
    end

    prefill_ff();
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check_eq("rdy_resweep", {31'b0, ready1}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      idle(); set_b(1'b0, ADRW'(i), '0, '0); step();
      check_eq("sweep_zero", q_b0, 32'd0);
    end

    // Byte-lane merge.
    idle(); set_a(1'b1, 4'd3, 32'hAABB_CCDD, 4'hF); step();
    idle(); set_a(1'b1, 4'd3, 32'h1122_3344, 4'b0101); step();
    idle(); set_b(1'b0, 4'd3, '0, '0); step();
    check_eq("be_lat1", q_b0, 32'hAA22_CC44);
    idle(); step();
    check_eq("be_lat2", q_b1, 32'hAA22_CC44);

    // Read-during-write, same port and cross port.
    idle(); set_a(1'b1, 4'd5, 32'h1, 4'hF); step();
    idle(); set_a(1'b0, 4'd3, '0, '0); step();
    idle(); set_a(1'b1, 4'd5, 32'h2, 4'hF); set_b(1'b0, 4'd5, '0, '0); step();
    check_eq("rdw_old_qb", q_b0, 32'h1);
    check_eq("rdw_old_qa", q_a0, 32'hAA22_CC44);
    idle(); step();
    check_eq("rdw_new_qb", q_b1, 32'h2);
    check_eq("rdw_new_qa", q_a1, 32'h2);

    // Dual write collision, then non-overlapping lanes.
    idle(); set_a(1'b1, 4'd7, 32'h0000_CCAA, 4'b0011); set_b(1'b1, 4'd7, 32'h00DD_BB00, 4'b0110); step();
    check_eq("coll_hi", {31'b0, coll0}, 32'd1);
    idle(); step();
    check_eq("coll_pulse", {31'b0, coll0}, 32'd0);
    idle(); set_a(1'b0, 4'd7, '0, '0); step();
    check_eq("coll_word", q_a0, 32'h00DD_CCAA);
    idle(); set_a(1'b1, 4'd7, 32'h0000_CCAA, 4'b0011); set_b(1'b1, 4'd7, 32'h5566_0000, 4'b1100); step();
    check_eq("no_coll", {31'b0, coll1}, 32'd0);
    idle(); set_a(1'b0, 4'd7, '0, '0); step();
    check_eq("split_word", q_a0, 32'h5566_CCAA);

    // Disabled port holds while address moves.
    idle(); address_a = 4'd9; step();
    check_eq("hold1", q_a0, 32'h5566_CCAA);
    address_a = 4'd3; step();
    check_eq("hold2", q_a0, 32'h5566_CCAA);

    // Reset at clear counter 9 restarts a full sweep.
    prefill_ff();
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1; step();
    check_eq("mid_rst_rdy", {31'b0, ready0}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("restart_lo", {31'b0, ready0}, 32'd0);
    step();
    check_eq("restart_hi", {31'b0, ready0}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      idle(); set_a(1'b0, ADRW'(i), '0, '0); step();
      check_eq("restart_zero", q_a0, 32'd0);
    end

    // Random traffic on a narrow address range to provoke collisions and forwarding.
    for (int n = 0; n < 80; n++) begin
      en_a = 1'($urandom_range(0, 1)); wren_a = 1'($urandom_range(0, 1));
      en_b = 1'($urandom_range(0, 1)); wren_b = 1'($urandom_range(0, 1));
      be_a = 4'($urandom); be_b = 4'($urandom);
      address_a = 4'($urandom_range(0, 3)); address_b = 4'($urandom_range(0, 3));
      data_a = $urandom; data_b = $urandom;
      step();
    end
    idle(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpram_cfg.md
# dpram_cfg

Parametrised true dual-port synchronous RAM, the next generation of the plain `dpram` used across the design. It adds configurable byte lanes with byte enables, per-port clock enables, and a selectable read-during-write mode with cross-port forwarding. It also adds an optional second output register, write-collision detection and a hardware clear-on-reset sweep with a ready flag. Cache tag/data arrays and FIFO storage instantiate it where known-zero contents after reset are required.

## Interface
- `ADRW`, 8: address width; depth = 2**ADRW words.
- `DATW`, 32: data width; must be a multiple of `BYTW`.
- `BYTW`, 8: byte-lane width; lane count NB = DATW/BYTW.
- `RDW_NEW`, 0: 0 = read-during-write returns old data; 1 = returns newly written (merged) data.
- `OUT_REG`, 0: 1 adds a second output register stage.
- `CLR_ON_RST`, 1: 1 = zero the whole array after reset.
- `clock` input 1: single clock, all ports.
- `reset` input 1: synchronous, active-high.
- `ready` output 1: array accessible; low while in reset or clearing.
- `en_a`, `en_b` input 1: port clock enable.
- `wren_a`, `wren_b` input 1: write enable (qualified by en_x).
- `be_a`, `be_b` input NB: byte-lane enables.
- `address_a`, `address_b` input ADRW: word address.
- `data_a`, `data_b` input DATW: write data.
- `q_a`, `q_b` output DATW: read data.
- `coll` output 1: pulse; both ports wrote the same address with overlapping lanes.

## Operation
- FSM states: CLEAR, RUN. `reset` high → state CLEAR (if CLR_ON_RST) else RUN, clear counter = 0, `ready`=0, `q_a`=`q_b`=0, all pipeline regs = 0, `coll`=0.
- CLEAR (after reset released): each cycle writes all-zero to mem[counter], counter+1; after writing address 2**ADRW-1 → RUN. Takes exactly 2**ADRW cycles. Port inputs ignored: writes dropped, reads not performed, q held 0.
- RUN: `ready`=1. Port x active when en_x=1.
- Write (en_x & wren_x): lanes with be_x[i]=1 take data_x[i*BYTW +: BYTW]; other lanes unchanged. be_x=0 → no change.
- Read (en_x & !wren_x): stage-1 register ← mem[address_x]. en_x=0: stage-1 holds.
- Same-port read-during-write (en_x & wren_x): RDW_NEW=0 → stage-1 holds previous value; RDW_NEW=1 → stage-1 ← merged new word (old lanes where be=0).
- Cross-port: port y reads address port x writes same cycle: RDW_NEW=0 → old word; RDW_NEW=1 → merged word (forwarded).
- Dual write, same address: non-overlapping lanes both applied; overlapping lanes take port A data; `coll`=1 next cycle iff (be_a & be_b)≠0. Different addresses never collide.
- OUT_REG=1: stage-2 ← stage-1 every cycle in RUN; q = stage-2. OUT_REG=0: q = stage-1.
- `reset` asserted mid-CLEAR or mid-RUN: restart per reset rule; array contents undefined until next sweep completes (CLR_ON_RST=0: contents retained).

## Timing
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from address sample edge to q valid.
- Write visible to any read issued on the next cycle (no extra hazard).
- `ready` rises on the first edge after the last clear write (CLR_ON_RST=1: 2**ADRW cycles after `reset` falls; CLR_ON_RST=0: 1 cycle after).
- `coll` is registered: asserted 1 cycle after the colliding edge, for 1 cycle.
- No combinational path from inputs to outputs.

## Test plan
- ADRW=4, CLR_ON_RST=1, memory pre-filled with 0xFFFFFFFF via writes; pulse reset → ready low exactly 16 cycles after reset falls, then every address reads 0x00000000.
- Port A writes 0xAABBCCDD at 3, then be_a=4'b0101 with 0x11223344 → port B reads 0xAA22CC44 at latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- RDW_NEW=0: address 5 holds 0x1; A writes 0x2 to 5 while B reads 5 → q_b=0x1, q_a holds prior value; RDW_NEW=1 → q_b=0x2, q_a=0x2.
- Both ports write address 7, be_a=4'b0011 data 0x000000AA…, be_b=4'b0110 data 0x0000BB00 → mem[7] low half from A, lane 2 from B, coll=1 one cycle; be_b=4'b1100 → coll stays 0.
- en_a=0 with address changing → q_a unchanged; reads during CLEAR → q=0, writes during CLEAR not retained.
- Reset asserted at clear counter = 9 → ready stays low, sweep restarts, full 16-cycle clear after reset release.
